// File: rtl/gate_test_sequencer_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding and the
// truth tables of the 2-input gates, so benches can pick EXPECT by name.
package gate_test_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit i is the gate output for input vector i (vec[1]=x, vec[0]=y).
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Sequencer-side bundle: sweep control, GUT stimulus/response and results.
interface gate_test_sequencer_if #(
  parameter int N_IN = 2
);
  import gate_test_sequencer_pkg::*;

  // Handshake: start is level-sampled on a rising clk edge and accepted only
  // when busy=0; an accepted start raises busy on that edge and clears done.
  // busy stays high for 2**N_IN*(HOLD+1) cycles, then done rises with busy
  // falling on the same edge; results are valid while done=1.
  logic            start;
  logic            gut_s;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;
  logic            fail_seen;
  state_t          dbg_state;

  modport master (
    input  start, gut_s,
    output vec, busy, done, pass, err_count, fail_vec, fail_seen, dbg_state
  );

  modport slave (
    output start, gut_s,
    input  vec, busy, done, pass, err_count, fail_vec, fail_seen, dbg_state
  );

endinterface

// File: rtl/gts_hold_counter.sv
// Per-vector settle counter: cleared by load, counts while en, and flags the
// last of HOLD settle cycles through tc.
module gts_hold_counter #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign tc = (cnt == CNT_LAST);

endmodule

// File: rtl/gate_test_sequencer.sv
// Clocked sweep of every GUT input vector with a registered compare against
// EXPECT. Define GTS_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_test_sequencer
  import gate_test_sequencer_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  HOLD   = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = TT_NAND
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_test_sequencer_if.master bus
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t          state;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] fail_vec_q;
  logic            fail_seen_q;

  logic mismatch;
  logic sweep_end;
  logic hold_tc;

  // gut_s only feeds this compare; every output below is a register.
  assign mismatch = (bus.gut_s != EXPECT[vec_q]);

`ifdef GTS_STOP_ON_FAIL_EN
  assign sweep_end = mismatch || (vec_q == VEC_LAST);
`else
  assign sweep_end = (vec_q == VEC_LAST);
`endif

  // Held clear outside APPLY so each vector starts its settle count at zero.
  gts_hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state != ST_APPLY),
    .en    (state == ST_APPLY),
    .tc    (hold_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state       <= ST_APPLY;
            vec_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_seen_q <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (hold_tc) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + ERR_ONE;
            if (!fail_seen_q) begin
              fail_vec_q  <= vec_q;
              fail_seen_q <= 1'b1;
            end
          end
          if (sweep_end) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == '0) && !mismatch;
          end else begin
            state <= ST_APPLY;
            vec_q <= vec_q + VEC_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec       = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_seen = fail_seen_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: a GUT model driven by a selectable truth
// table, table-driven and random sweeps, and hand-written start/reset cases.
module tb_gate_test_sequencer;
  import gate_test_sequencer_pkg::*;

  localparam int         N_IN   = 2;
  localparam int         HOLD   = 1;
  localparam int         NV     = 4;
  localparam logic [3:0] EXP_TT = TT_NAND;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_test_sequencer_if #(.N_IN(N_IN)) bus();

  logic [3:0] gut_tt;
  assign bus.gut_s = gut_tt[bus.vec];

  gate_test_sequencer #(
    .N_IN   (N_IN),
    .HOLD   (HOLD),
    .EXPECT (EXP_TT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [N_IN-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         err;
    logic [1:0] fv;
    logic       pass;
    int         nvec;
  } res_t;

  function automatic res_t model(input logic [3:0] tt);
    res_t r;
    r.err  = 0;
    r.fv   = 2'd0;
    r.nvec = NV;
    for (int i = 0; i < NV; i++) begin
      if (tt[i] != EXP_TT[i]) begin
        if (r.err == 0) begin
          r.fv = 2'(i);
`ifdef GTS_STOP_ON_FAIL_EN
          r.nvec = i + 1;
`endif
        end
        r.err++;
      end
    end
`ifdef GTS_STOP_ON_FAIL_EN
    if (r.err > 1) r.err = 1;
`endif
    r.pass = (r.err == 0);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input logic [3:0] tt, input int exp_err,
                           input logic [1:0] exp_fv, input logic exp_pass,
                           input int exp_nvec, input bit repulse,
                           input string tag);
    int  n;
    bit  got_done;
    logic [N_IN-1:0] ev;
    gut_tt = tt;
    exp_q.delete();
    for (int v = 0; v < exp_nvec; v++)
      for (int h = 0; h <= HOLD; h++) exp_q.push_back(2'(v));
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 100) begin
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_cycle"}, 1, 0);
        end else begin
          ev = exp_q.pop_front();
          check({tag, "_vec"}, int'(bus.vec), int'(ev));
        end
        check({tag, "_busy"}, int'(bus.busy), 1);
        check({tag, "_pass_hidden"}, int'(bus.pass), 0);
        bus.start = (repulse && (n == 1 || n == 3)) ? 1'b1 : 1'b0;
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, n, exp_nvec * (HOLD + 1));
    check({tag, "_done"}, int'(bus.done), 1);
    check({tag, "_busy_end"}, int'(bus.busy), 0);
    check({tag, "_err_count"}, int'(bus.err_count), exp_err);
    check({tag, "_fail_vec"}, int'(bus.fail_vec), int'(exp_fv));
    check({tag, "_fail_seen"}, int'(bus.fail_seen), (exp_err != 0) ? 1 : 0);
    check({tag, "_pass"}, int'(bus.pass), int'(exp_pass));
    check({tag, "_state"}, int'(bus.dbg_state), int'(ST_DONE));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, int'(bus.done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"}, int'(bus.vec), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_pass"}, int'(bus.pass), 0);
    check({tag, "_err"}, int'(bus.err_count), 0);
    check({tag, "_fvec"}, int'(bus.fail_vec), 0);
    check({tag, "_fseen"}, int'(bus.fail_seen), 0);
    check({tag, "_state"}, int'(bus.dbg_state), int'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [3:0] tt;
    int         err;
    logic [1:0] fv;
    logic       pass;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int         e;
    int         nv;
    res_t       r;
    logic [3:0] tt;
    int         wait_n;

    bus.start = 1'b0;
    gut_tt    = TT_NAND;

    tbl[0] = '{"nand",   TT_NAND, 0, 2'd0, 1'b1};
    tbl[1] = '{"stuck1", 4'b1111, 1, 2'd3, 1'b0};
    tbl[2] = '{"stuck0", 4'b0000, 3, 2'd0, 1'b0};
    tbl[3] = '{"nor",    TT_NOR,  2, 2'd1, 1'b0};
    tbl[4] = '{"and",    TT_AND,  4, 2'd0, 1'b0};
    tbl[5] = '{"or",     TT_OR,   2, 2'd0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // Table-driven sweeps; the first one also re-pulses start mid-sweep
    for (int i = 0; i < 6; i++) begin
      e  = tbl[i].err;
      nv = NV;
`ifdef GTS_STOP_ON_FAIL_EN
      if (e > 0) begin
        e  = 1;
        nv = int'(tbl[i].fv) + 1;
      end
`endif
      run_sweep(tbl[i].tt, e, tbl[i].fv, tbl[i].pass, nv, (i == 0), tbl[i].name);
    end

    // Second start in DONE (after a failing sweep): clears on the accept edge
    run_sweep(4'b0000, model(4'b0000).err, model(4'b0000).fv,
              model(4'b0000).pass, model(4'b0000).nvec, 1'b0, "pre_restart");
    gut_tt = TT_NAND;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("restart_done", int'(bus.done), 0);
    check("restart_err", int'(bus.err_count), 0);
    check("restart_busy", int'(bus.busy), 1);
    check("restart_vec", int'(bus.vec), 0);
    check("restart_fseen", int'(bus.fail_seen), 0);
    wait_done("restart");

    // Reset mid-sweep at vec=2
`ifdef GTS_STOP_ON_FAIL_EN
    gut_tt = TT_NAND;
`else
    gut_tt = 4'b0000;
`endif
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_n = 0;
    while (bus.vec != 2'd2 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("midrst_reach_vec2", int'(bus.vec), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(TT_NAND, 0, 2'd0, 1'b1, NV, 1'b0, "post_rst");

    // Random sweeps against the model
    for (int i = 0; i < 10; i++) begin
      tt = 4'($urandom_range(0, 15));
      r  = model(tt);
      run_sweep(tt, r.err, r.fv, r.pass, r.nvec, bit'($urandom_range(0, 1)),
                $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
